chargen_pixel_pipe: RTL

- Pixel-path stage directly downstream of the VGA timing generator.
- Consumes the generator's hcount/vcount, pixel enable and hs/vs outputs. Turns them into 12-bit RGB by fetching a character code and attribute from the text-map RAM, then the glyph row from the font ROM.
- Delays sync and enable so they stay aligned with the colour.
- Text mode: 80x30 cells of 8x16 pixels on 640x480.

---
 rtl/chargen_pkg.sv | 43 ++++
 rtl/chargen_delay_line.sv | 27 ++
 rtl/chargen_pixel_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/chargen_pkg.sv
// Shared types, glyph geometry, text-word field offsets and the 16-entry CGA palette
// for the character-generator pixel path.
package chargen_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    // Text-map word layout: [7:0] code, [11:8] fg index, [15:12] bg index
    localparam int TXT_CODE_LSB = 0;
    localparam int TXT_FG_LSB   = 8;
    localparam int TXT_BG_LSB   = 12;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [2:0] xlo;
        logic [3:0] ylo;
        logic       cur;
    } side_t;

    function automatic logic [11:0] palette(input logic [3:0] idx);
        case (idx)
            4'd0:    return 12'h000;
            4'd1:    return 12'h00A;
            4'd2:    return 12'h0A0;
            4'd3:    return 12'h0AA;
            4'd4:    return 12'hA00;
            4'd5:    return 12'hA0A;
            4'd6:    return 12'hA50;
            4'd7:    return 12'hAAA;
            4'd8:    return 12'h555;
            4'd9:    return 12'h55F;
            4'd10:   return 12'h5F5;
            4'd11:   return 12'h5FF;
            4'd12:   return 12'hF55;
            4'd13:   return 12'hF5F;
            4'd14:   return 12'hFF5;
            default: return 12'hFFF;
        endcase
    endfunction

endpackage

// File: rtl/chargen_delay_line.sv
// Fixed-depth register chain with synchronous active-low reset to RST_VAL.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module chargen_delay_line #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q_o = stage[DEPTH-1];

endmodule

// File: rtl/chargen_pixel_pipe.sv
// Text-mode pixel path: timing-generator counters -> text-map -> font ROM -> 12-bit RGB.
// Latency 5 cycles for rgb/de/hs/vs; no backpressure. Optional cursor blink: CHARGEN_CURSOR_BLINK_EN.
module chargen_pixel_pipe
    import chargen_pkg::*;
#(
    parameter int   COLS      = 80,
    parameter int   ROWS      = 30,
    parameter int   HCNT_W    = 10,
    parameter int   VCNT_W    = 10,
    parameter int   ADDR_W    = $clog2(COLS*ROWS),
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [HCNT_W-1:0] hcount_i,
    input  logic [VCNT_W-1:0] vcount_i,
    input  logic              pixel_enable_i,
    input  logic              hs_i,
    input  logic              vs_i,
    output logic [ADDR_W-1:0] ch_addr_o,
    input  logic [15:0]       ch_data_i,
    output logic [11:0]       font_addr_o,
    input  logic [7:0]        font_row_i,
    input  logic [6:0]        cursor_x_i,
    input  logic [4:0]        cursor_y_i,
    output logic [11:0]       rgb_o,
    output logic              de_o,
    output logic              hs_o,
    output logic              vs_o
);

    localparam int    XSH      = $clog2(GLYPH_W);
    localparam int    YSH      = $clog2(GLYPH_H);
    localparam side_t SIDE_RST = '{de: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE,
                                   xlo: 3'd0, ylo: 4'd0, cur: 1'b0};

    logic [ADDR_W-1:0] row_a, col_a, row_base, addr_next;
    logic              cursor_hit;
    side_t             side_in, side2, side4;
    logic [7:0]        colour4;
    logic [2:0]        bit_idx;
    logic              pix;
    logic [3:0]        colour_idx;

    assign row_a = ADDR_W'(vcount_i >> YSH);
    assign col_a = ADDR_W'(hcount_i >> XSH);

    generate
        if (COLS == 80) begin : g_mul80
            assign row_base = (row_a << 6) + (row_a << 4);
        end else begin : g_mul
            assign row_base = row_a * ADDR_W'(COLS);
        end
    endgenerate

    assign addr_next = row_base + col_a;

`ifdef CHARGEN_CURSOR_BLINK_EN
    logic [4:0] frame_cnt;
    logic       vs_prev;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            frame_cnt <= '0;
            vs_prev   <= SYNC_IDLE;
        end else begin
            vs_prev <= vs_i;
            if (vs_prev == SYNC_IDLE && vs_i != SYNC_IDLE) frame_cnt <= frame_cnt + 5'd1;
        end
    end

    assign cursor_hit = !frame_cnt[4]
                     && (hcount_i[HCNT_W-1:XSH] == (HCNT_W-XSH)'(cursor_x_i))
                     && (vcount_i[VCNT_W-1:YSH] == (VCNT_W-YSH)'(cursor_y_i));
`else
    logic unused_cursor;
    assign cursor_hit    = 1'b0;
    assign unused_cursor = ^{cursor_x_i, cursor_y_i};
`endif

    assign side_in = '{de: pixel_enable_i, hs: hs_i, vs: vs_i,
                       xlo: hcount_i[2:0], ylo: vcount_i[3:0], cur: cursor_hit};

    // Two taps: side2 lines up with ch_data_i (P3), side4 with font_row_i (P5).
    chargen_delay_line #(.W($bits(side_t)), .DEPTH(2), .RST_VAL(SIDE_RST)) u_side_a (
        .clk_i(clk_i), .rstn_i(rstn_i), .d_i(side_in), .q_o(side2));

    chargen_delay_line #(.W($bits(side_t)), .DEPTH(2), .RST_VAL(SIDE_RST)) u_side_b (
        .clk_i(clk_i), .rstn_i(rstn_i), .d_i(side2), .q_o(side4));

    chargen_delay_line #(.W(8), .DEPTH(2), .RST_VAL(8'h00)) u_colour (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .d_i({ch_data_i[TXT_BG_LSB +: 4], ch_data_i[TXT_FG_LSB +: 4]}),
        .q_o(colour4));

    // Memory addresses freeze during blanking to keep the RAM/ROM buses quiet.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ch_addr_o   <= '0;
            font_addr_o <= '0;
        end else begin
            if (pixel_enable_i) ch_addr_o <= addr_next;
            if (side2.de)       font_addr_o <= {ch_data_i[TXT_CODE_LSB +: 8], side2.ylo};
        end
    end

    always_comb begin
        bit_idx    = 3'(GLYPH_W-1) - side4.xlo;
        pix        = font_row_i[bit_idx] | (side4.cur && side4.ylo >= 4'(GLYPH_H-2));
        colour_idx = pix ? colour4[3:0] : colour4[7:4];
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rgb_o <= '0;
            de_o  <= 1'b0;
            hs_o  <= SYNC_IDLE;
            vs_o  <= SYNC_IDLE;
        end else begin
            rgb_o <= side4.de ? palette(colour_idx) : 12'h000;
            de_o  <= side4.de;
            hs_o  <= side4.hs;
            vs_o  <= side4.vs;
        end
    end

endmodule
